// File: rtl/gate_chk_pkg.sv
// Shared constants and FSM encoding for the gate bank self-test.
package gate_chk_pkg;

  localparam int NUM_GATES = 10;
  localparam int NUM_VEC   = 4;

  localparam int GATE_AND   = 0;
  localparam int GATE_OR    = 1;
  localparam int GATE_NOT_A = 2;
  localparam int GATE_NOT_B = 3;
  localparam int GATE_NAND  = 4;
  localparam int GATE_NOR   = 5;
  localparam int GATE_XOR   = 6;
  localparam int GATE_XNOR  = 7;
  localparam int GATE_BUF_A = 8;
  localparam int GATE_BUF_B = 9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/gate_expect.sv
// Combinational reference model: the ten gate-bank outputs expected for inputs (a, b).
module gate_expect
  import gate_chk_pkg::*;
(
  input  logic                 a,
  input  logic                 b,
  output logic [NUM_GATES-1:0] exp_gates
);

  always_comb begin
    exp_gates             = '0;
    exp_gates[GATE_AND]   = a & b;
    exp_gates[GATE_OR]    = a | b;
    exp_gates[GATE_NOT_A] = ~a;
    exp_gates[GATE_NOT_B] = ~b;
    exp_gates[GATE_NAND]  = ~(a & b);
    exp_gates[GATE_NOR]   = ~(a | b);
    exp_gates[GATE_XOR]   = a ^ b;
    exp_gates[GATE_XNOR]  = ~(a ^ b);
    exp_gates[GATE_BUF_A] = a;
    exp_gates[GATE_BUF_B] = b;
  end

endmodule

// File: rtl/gate_bank_checker.sv
// Sweeps the gate bank through 00,01,10,11 and compares each result after a settle delay.
// Optional first-failure capture is compiled in with GATE_CHK_ERR_LOG_EN.
module gate_bank_checker
  import gate_chk_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 start_in,
  input  logic [NUM_GATES-1:0] gates_in,
  output logic                 a_out,
  output logic                 b_out,
  output logic                 busy_out,
  output logic                 done_out,
  output logic                 pass_out,
  output logic [2:0]           fail_count_out,
  output logic [NUM_GATES-1:0] fail_mask_out,
`ifdef GATE_CHK_ERR_LOG_EN
  output logic                 first_fail_vld_out,
  output logic [1:0]           first_fail_vec_out,
  output logic [NUM_GATES-1:0] first_fail_obs_out,
`endif
  output state_e               dbg_state_out
);

  // start_in is a level sampled only in IDLE/DONE; no valid/ready handshake here.
  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [1:0] VEC_LAST = 2'(NUM_VEC - 1);

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [1:0]           vec_q, vec_d;
  logic [2:0]           count_q, count_d;
  logic [NUM_GATES-1:0] mask_q, mask_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic [NUM_GATES-1:0] exp_gates;
  logic [NUM_GATES-1:0] mism;
`ifdef GATE_CHK_ERR_LOG_EN
  logic                 ff_vld_q, ff_vld_d;
  logic [1:0]           ff_vec_q, ff_vec_d;
  logic [NUM_GATES-1:0] ff_obs_q, ff_obs_d;
`endif

  gate_expect u_expect (
    .a         (vec_q[1]),
    .b         (vec_q[0]),
    .exp_gates (exp_gates)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    count_d = count_q;
    mask_d  = mask_q;
    mism    = '0;
`ifdef GATE_CHK_ERR_LOG_EN
    ff_vld_d = ff_vld_q;
    ff_vec_d = ff_vec_q;
    ff_obs_d = ff_obs_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start_in) begin
          state_d = SETTLE;
          cnt_d   = '0;
          vec_d   = '0;
          count_d = '0;
          mask_d  = '0;
`ifdef GATE_CHK_ERR_LOG_EN
          ff_vld_d = 1'b0;
          ff_vec_d = '0;
          ff_obs_d = '0;
`endif
        end
      end
      SETTLE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == CNT_LAST) state_d = CHECK;
      end
      CHECK: begin
        mism   = gates_in ^ exp_gates;
        mask_d = mask_q | mism;
        // At most NUM_VEC failures, so the 3-bit counter never wraps.
        if (mism != '0) count_d = count_q + 3'd1;
`ifdef GATE_CHK_ERR_LOG_EN
        if (mism != '0 && !ff_vld_q) begin
          ff_vld_d = 1'b1;
          ff_vec_d = vec_q;
          ff_obs_d = gates_in;
        end
`endif
        if (vec_q == VEC_LAST) begin
          state_d = DONE;
        end else begin
          vec_d   = vec_q + 2'd1;
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SETTLE) || (state_d == CHECK);
    done_d = (state_d == DONE);
    pass_d = done_d && (count_d == 3'd0);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vec_q   <= '0;
      count_q <= '0;
      mask_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
`ifdef GATE_CHK_ERR_LOG_EN
      ff_vld_q <= 1'b0;
      ff_vec_q <= '0;
      ff_obs_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      count_q <= count_d;
      mask_q  <= mask_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
`ifdef GATE_CHK_ERR_LOG_EN
      ff_vld_q <= ff_vld_d;
      ff_vec_q <= ff_vec_d;
      ff_obs_q <= ff_obs_d;
`endif
    end
  end

  assign a_out          = vec_q[1];
  assign b_out          = vec_q[0];
  assign busy_out       = busy_q;
  assign done_out       = done_q;
  assign pass_out       = pass_q;
  assign fail_count_out = count_q;
  assign fail_mask_out  = mask_q;
  assign dbg_state_out  = state_q;
`ifdef GATE_CHK_ERR_LOG_EN
  assign first_fail_vld_out = ff_vld_q;
  assign first_fail_vec_out = ff_vec_q;
  assign first_fail_obs_out = ff_obs_q;
`endif

endmodule

// File: tb/tb_gate_bank_checker.sv
// Directed bench for gate_bank_checker: emulated gate bank with injectable faults.
module tb_gate_bank_checker;
  import gate_chk_pkg::*;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       start_in;
  logic [9:0] gates_in;
  logic       a_out, b_out, busy_out, done_out, pass_out;
  logic [2:0] fail_count_out;
  logic [9:0] fail_mask_out;
  state_e     dbg_state_out;
`ifdef GATE_CHK_ERR_LOG_EN
  logic       first_fail_vld_out;
  logic [1:0] first_fail_vec_out;
  logic [9:0] first_fail_obs_out;
`endif

  int total = 0;
  int bad   = 0;

  // Fault injection on the emulated gate bank.
  logic [9:0] stuck0 = '0, stuck1 = '0, invert = '0;
  logic [9:0] golden;

  // Snapshot taken one edge after start is sampled.
  logic       snap_busy, snap_done;
  logic [2:0] snap_cnt;
  logic [9:0] snap_mask;

  int          lat;
  logic [23:0] ab_seq, ab_exp;
  int          idle_bad;

  always #5 clk_in = ~clk_in;

  // Bit order MSB..LSB: buf_b buf_a xnor xor nor nand not_b not_a or and
  always_comb begin
    golden   = {b_out, a_out, ~(a_out ^ b_out), a_out ^ b_out, ~(a_out | b_out),
                ~(a_out & b_out), ~b_out, ~a_out, a_out | b_out, a_out & b_out};
    gates_in = ((golden & ~stuck0) | stuck1) ^ invert;
  end

  gate_bank_checker #(.SETTLE_CYCLES(2)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .start_in       (start_in),
    .gates_in       (gates_in),
    .a_out          (a_out),
    .b_out          (b_out),
    .busy_out       (busy_out),
    .done_out       (done_out),
    .pass_out       (pass_out),
    .fail_count_out (fail_count_out),
    .fail_mask_out  (fail_mask_out),
`ifdef GATE_CHK_ERR_LOG_EN
    .first_fail_vld_out (first_fail_vld_out),
    .first_fail_vec_out (first_fail_vec_out),
    .first_fail_obs_out (first_fail_obs_out),
`endif
    .dbg_state_out  (dbg_state_out)
  );

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after the edge; outputs are sampled at the same point.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic run_sweep(input bit hold, output int l, output logic [23:0] seq);
    start_in = 1'b1;
    tick();
    if (!hold) start_in = 1'b0;
    snap_busy = busy_out;
    snap_done = done_out;
    snap_cnt  = fail_count_out;
    snap_mask = fail_mask_out;
    seq = '0;
    seq[23 -: 2] = {a_out, b_out};
    l = -1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (n < 12) seq[23 - 2*n -: 2] = {a_out, b_out};
      if (done_out) begin
        l = n;
        break;
      end
    end
    start_in = 1'b0;
  endtask

  task automatic check_results(input string tag, input logic p, input logic [2:0] c,
                               input logic [9:0] m);
    chk_eq({tag, "_lat"}, 32'(lat), 32'd12);
    chk_eq({tag, "_pass"}, 32'(pass_out), 32'(p));
    chk_eq({tag, "_count"}, 32'(fail_count_out), 32'(c));
    chk_eq({tag, "_mask"}, 32'(fail_mask_out), 32'(m));
  endtask

  initial begin
    for (int k = 0; k < 12; k++) ab_exp[23 - 2*k -: 2] = 2'(k / 3);

    rst_in   = 1'b1;
    start_in = 1'b0;
    repeat (3) tick();
    rst_in = 1'b0;
    tick();
    chk_eq("rst_state", 32'(dbg_state_out), 32'(IDLE));
    chk_eq("rst_ab", 32'({a_out, b_out}), 32'd0);
    chk_eq("rst_busy_done_pass", 32'({busy_out, done_out, pass_out}), 32'd0);
    chk_eq("rst_count", 32'(fail_count_out), 32'd0);
    chk_eq("rst_mask", 32'(fail_mask_out), 32'd0);

    // Golden bank
    run_sweep(1'b0, lat, ab_seq);
    chk_eq("gold_busy_edge0", 32'(snap_busy), 32'd1);
    chk_eq("gold_ab_seq", 32'(ab_seq), 32'(ab_exp));
    check_results("gold", 1'b1, 3'd0, 10'h000);
    chk_eq("gold_busy_done", 32'(busy_out), 32'd0);
    chk_eq("gold_ab_hold", 32'({a_out, b_out}), 32'd3);
    chk_eq("gold_state", 32'(dbg_state_out), 32'(DONE));

    // xor stuck at 0: fails for 01 and 10
    stuck0 = 10'h040;
    run_sweep(1'b0, lat, ab_seq);
    chk_eq("xor_done_drop", 32'(snap_done), 32'd0);
    check_results("xor", 1'b0, 3'd2, 10'h040);
    stuck0 = '0;

    // All outputs inverted
    invert = 10'h3FF;
    run_sweep(1'b0, lat, ab_seq);
    check_results("inv", 1'b0, 3'd4, 10'h3FF);
    invert = '0;

    // New start from DONE clears results on the next edge
    run_sweep(1'b0, lat, ab_seq);
    chk_eq("restart_done_drop", 32'(snap_done), 32'd0);
    chk_eq("restart_count_clr", 32'(snap_cnt), 32'd0);
    chk_eq("restart_mask_clr", 32'(snap_mask), 32'd0);
    check_results("restart", 1'b1, 3'd0, 10'h000);

    // nand stuck at 1: fails only for 11
    stuck1 = 10'h010;
    run_sweep(1'b0, lat, ab_seq);
    check_results("nand", 1'b0, 3'd1, 10'h010);
`ifdef GATE_CHK_ERR_LOG_EN
    chk_eq("nand_ff_vld", 32'(first_fail_vld_out), 32'd1);
    chk_eq("nand_ff_vec", 32'(first_fail_vec_out), 32'd3);
    chk_eq("nand_ff_obs4", 32'(first_fail_obs_out[4]), 32'd1);
`endif
    stuck1 = '0;

    // start held high: one sweep only
    run_sweep(1'b1, lat, ab_seq);
    chk_eq("hold_lat", 32'(lat), 32'd12);
    chk_eq("hold_ab_seq", 32'(ab_seq), 32'(ab_exp));
    tick();
    chk_eq("hold_still_done", 32'(done_out), 32'd1);

    // Reset during SETTLE of vec=2
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    repeat (6) tick();
    chk_eq("mid_ab_vec2", 32'({a_out, b_out}), 32'd2);
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    chk_eq("mid_rst_state", 32'(dbg_state_out), 32'(IDLE));
    chk_eq("mid_rst_ab", 32'({a_out, b_out}), 32'd0);
    chk_eq("mid_rst_busy_done", 32'({busy_out, done_out}), 32'd0);
    idle_bad = 0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (busy_out || done_out || a_out || b_out || dbg_state_out != IDLE) idle_bad++;
    end
    chk_eq("mid_rst_stay_idle", 32'(idle_bad), 32'd0);

    // Reset and start together: reset wins
    rst_in   = 1'b1;
    start_in = 1'b1;
    tick();
    rst_in   = 1'b0;
    start_in = 1'b0;
    chk_eq("rst_start_state", 32'(dbg_state_out), 32'(IDLE));
    chk_eq("rst_start_busy", 32'(busy_out), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
